// File: rtl/mem_miss_arbiter_if.sv
// Shared request type and the arbiter's cache/memory-side bundle.
// master drives requests and memory responses; slave is the arbiter.
package mem_arb_pkg;
  localparam int DCACHE_LINE_WIDTH = 128;

  typedef struct packed {
    logic [31:0]                  addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;
endpackage

interface mem_miss_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int LINE_W = DCACHE_LINE_WIDTH
);
  logic              icache_req_valid;
  memory_request_t   icache_req_info;
  logic              dcache_req_valid;
  memory_request_t   dcache_req_info;
  logic              rsp_valid;
  logic              rsp_cache_id;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_bus_error;
  logic              mm_req_valid;
  memory_request_t   mm_req_info;
  logic              mm_rsp_valid;
  logic [LINE_W-1:0] mm_rsp_data;
  logic              mm_rsp_bus_error;
  logic              protocol_err;

  modport slave (
    input  icache_req_valid, icache_req_info,
    input  dcache_req_valid, dcache_req_info,
    input  mm_rsp_valid, mm_rsp_data, mm_rsp_bus_error,
    output rsp_valid, rsp_cache_id, rsp_data, rsp_bus_error,
    output mm_req_valid, mm_req_info, protocol_err
  );

  modport master (
    output icache_req_valid, icache_req_info,
    output dcache_req_valid, dcache_req_info,
    output mm_rsp_valid, mm_rsp_data, mm_rsp_bus_error,
    input  rsp_valid, rsp_cache_id, rsp_data, rsp_bus_error,
    input  mm_req_valid, mm_req_info, protocol_err
  );
endinterface

// File: rtl/mem_miss_arbiter.sv
// I$/D$ miss arbiter onto one main-memory port, non-preemptive.
// MEM_ARB_FAIR_EN: alternate on ties instead of fixed D$ priority.
module mem_miss_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W  = DCACHE_LINE_WIDTH,
  parameter int LAT_REQ = 4
) (
  input logic              clock,
  input logic              reset_n,
  mem_miss_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, DELAY, MEM, RESP
  } state_t;

  localparam bit         HAS_DELAY = (LAT_REQ > 0);
  localparam logic [7:0] LAT_M1    = 8'(LAT_REQ - 1);

  state_t            state, state_nx;
  logic              i_vld, d_vld;
  memory_request_t   i_info, d_info;
  logic [7:0]        cnt;
  memory_request_t   req_q;
  logic              gnt_id;
  logic              rsp_id_q;
  logic [LINE_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              perr_q;

  logic              cand_i, cand_d;
  logic              pick_d, grant;
  logic              i_grant, d_grant;
  memory_request_t   sel_info;

`ifdef MEM_ARB_FAIR_EN
  logic last_gnt;
`endif

  always_comb begin
    cand_i = i_vld | bus.icache_req_valid;
    cand_d = d_vld | bus.dcache_req_valid;
`ifdef MEM_ARB_FAIR_EN
    pick_d = cand_d & (~cand_i | ~last_gnt);
`else
    pick_d = cand_d;
`endif
    grant   = (state == IDLE) & (cand_i | cand_d);
    i_grant = grant & ~pick_d;
    d_grant = grant & pick_d;
    if (pick_d)
      sel_info = d_vld ? d_info : bus.dcache_req_info;
    else
      sel_info = i_vld ? i_info : bus.icache_req_info;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = HAS_DELAY ? DELAY : MEM;
      DELAY:   if (cnt == LAT_M1) state_nx = MEM;
      MEM:     if (bus.mm_rsp_valid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // A pulse into a full slot is dropped; a bypass-granted pulse never lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_vld  <= 1'b0;
      d_vld  <= 1'b0;
      i_info <= '0;
      d_info <= '0;
      perr_q <= 1'b0;
    end else begin
      if ((bus.icache_req_valid & i_vld) |
          (bus.dcache_req_valid & d_vld))
        perr_q <= 1'b1;
      if (i_grant & i_vld) begin
        i_vld <= 1'b0;
      end else if (bus.icache_req_valid & ~i_vld & ~i_grant) begin
        i_vld  <= 1'b1;
        i_info <= bus.icache_req_info;
      end
      if (d_grant & d_vld) begin
        d_vld <= 1'b0;
      end else if (bus.dcache_req_valid & ~d_vld & ~d_grant) begin
        d_vld  <= 1'b1;
        d_info <= bus.dcache_req_info;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      req_q      <= '0;
      gnt_id     <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state == DELAY)
        cnt <= (cnt == LAT_M1) ? 8'd0 : cnt + 8'd1;
      if (grant) begin
        req_q  <= sel_info;
        gnt_id <= pick_d;
      end
      if ((state == MEM) & bus.mm_rsp_valid) begin
        rsp_data_q <= bus.mm_rsp_data;
        rsp_err_q  <= bus.mm_rsp_bus_error;
        rsp_id_q   <= gnt_id;
      end
    end
  end

`ifdef MEM_ARB_FAIR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   last_gnt <= 1'b0;
    else if (grant) last_gnt <= pick_d;
  end
`endif

  assign bus.mm_req_valid  = (state == MEM);
  assign bus.mm_req_info   = req_q;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_cache_id  = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_bus_error = rsp_err_q;
  assign bus.protocol_err  = perr_q;
endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed vector table plus hand sequences for mem_miss_arbiter.
module tb_mem_miss_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_miss_arbiter_if #(.LINE_W(128)) ifc4 ();
  mem_miss_arbiter_if #(.LINE_W(128)) ifc0 ();

  mem_miss_arbiter #(.LINE_W(128), .LAT_REQ(4)) dut4 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifc4.slave)
  );

  mem_miss_arbiter #(.LINE_W(128), .LAT_REQ(0)) dut0 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifc0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ireq;
    bit          dreq;
    bit          mrsp;
    logic [31:0] dw;
    bit          e_mreq;
    logic [31:0] e_addr;
    bit          e_rsp;
    bit          e_id;
    logic [31:0] e_dw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit i, bit d, bit r, logic [31:0] dw,
    bit em, logic [31:0] ea,
    bit er, bit eid, logic [31:0] edw
  );
    vec_t v;
    v.ireq = i;  v.dreq = d;  v.mrsp = r;  v.dw = dw;
    v.e_mreq = em; v.e_addr = ea;
    v.e_rsp = er; v.e_id = eid; v.e_dw = edw;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ifc4.icache_req_valid = 1'b0;
    ifc4.dcache_req_valid = 1'b0;
    ifc4.mm_rsp_valid     = 1'b0;
    ifc4.mm_rsp_bus_error = 1'b0;
    ifc0.icache_req_valid = 1'b0;
    ifc0.dcache_req_valid = 1'b0;
    ifc0.mm_rsp_valid     = 1'b0;
    ifc0.mm_rsp_bus_error = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    #3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit          fid;
    logic [31:0] fa, sa;
    int          wins, icnt, dcnt, n;
    bit          prev, got, id;
    memory_request_t ri, rd;

    total = 0;
    bad   = 0;
    ri = '0; ri.addr = 32'h1000;
    rd = '0; rd.addr = 32'h2000; rd.data = 128'hdead;
    ifc4.icache_req_info = ri; ifc4.dcache_req_info = rd;
    ifc0.icache_req_info = ri; ifc0.dcache_req_info = rd;
    ifc4.mm_rsp_data = '0;
    ifc0.mm_rsp_data = '0;
    do_reset();

    chk("rst_mreq", ifc4.mm_req_valid, 0);
    chk("rst_rsp", ifc4.rsp_valid, 0);
    chk("rst_perr", ifc4.protocol_err, 0);
    chk("rst_info", ifc4.mm_req_info[127:0], 0);
    chk("rst_data", ifc4.rsp_data, 0);
    chk("rst_mreq0", ifc0.mm_req_valid, 0);

    // single D$ load, then simultaneous I$+D$
    fid = FAIR ? 1'b0 : 1'b1;
    fa  = fid ? 32'h2000 : 32'h1000;
    sa  = fid ? 32'h1000 : 32'h2000;
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0,0));
    repeat (4) tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0));
    repeat (3) tbl.push_back(mk(0,0,0,0, 1,32'h2000, 0,0,0));
    tbl.push_back(mk(0,0,1,32'h11, 1,32'h2000, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,1,32'h11));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 0,0,0));
    repeat (4) tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,32'h22, 1,fa, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,fid,32'h22));
    repeat (5) tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,32'h33, 1,sa, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1,~fid,32'h33));
    tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0));

    wins = 0;
    prev = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      ifc4.icache_req_valid = tbl[i].ireq;
      ifc4.dcache_req_valid = tbl[i].dreq;
      ifc4.mm_rsp_valid     = tbl[i].mrsp;
      ifc4.mm_rsp_data      = {4{tbl[i].dw}};
      chk($sformatf("v%0d_mreq", i), ifc4.mm_req_valid, tbl[i].e_mreq);
      chk($sformatf("v%0d_rsp", i), ifc4.rsp_valid, tbl[i].e_rsp);
      chk($sformatf("v%0d_perr", i), ifc4.protocol_err, 0);
      if (tbl[i].e_mreq)
        chk($sformatf("v%0d_addr", i), ifc4.mm_req_info.addr,
            tbl[i].e_addr);
      if (tbl[i].e_rsp) begin
        chk($sformatf("v%0d_id", i), ifc4.rsp_cache_id, tbl[i].e_id);
        chk($sformatf("v%0d_data", i), ifc4.rsp_data,
            {4{tbl[i].e_dw}});
        chk($sformatf("v%0d_berr", i), ifc4.rsp_bus_error, 0);
      end
      if (i >= 11 && ifc4.mm_req_valid && !prev) wins++;
      prev = ifc4.mm_req_valid;
      tick();
    end
    clr_in();
    chk("two_windows", wins, 2);
    chk("hold_data", ifc4.rsp_data, {4{32'h33}});

    // D$ arrives while I$ is in MEM
    ifc4.icache_req_valid = 1'b1;
    tick();
    clr_in();
    n = 0;
    while (!ifc4.mm_req_valid && n < 20) begin tick(); n++; end
    chk("np_mreq_seen", ifc4.mm_req_valid, 1);
    ifc4.dcache_req_valid = 1'b1;
    tick();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      chk("np_addr_hold", ifc4.mm_req_info.addr, 32'h1000);
      tick();
    end
    ifc4.mm_rsp_valid = 1'b1;
    ifc4.mm_rsp_data  = {4{32'h44}};
    tick();
    clr_in();
    chk("np_rsp_i", {ifc4.rsp_valid, ifc4.rsp_cache_id}, 2'b10);
    chk("np_addr_resp", ifc4.mm_req_info.addr, 32'h1000);
    n = 0;
    while (!ifc4.mm_req_valid && n < 20) begin tick(); n++; end
    chk("np_addr_d", ifc4.mm_req_info.addr, 32'h2000);
    ifc4.mm_rsp_valid = 1'b1;
    tick();
    clr_in();
    chk("np_rsp_d", {ifc4.rsp_valid, ifc4.rsp_cache_id}, 2'b11);
    chk("np_perr", ifc4.protocol_err, 0);
    tick();

    // second I$ pulse into a full slot
    ifc4.dcache_req_valid = 1'b1;
    tick();
    clr_in();
    ifc4.icache_req_valid = 1'b1;
    tick();
    ifc4.icache_req_valid = 1'b1;
    tick();
    clr_in();
    chk("perr_set", ifc4.protocol_err, 1);
    icnt = 0;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      ifc4.mm_rsp_valid = ifc4.mm_req_valid;
      if (ifc4.rsp_valid) begin
        if (ifc4.rsp_cache_id) dcnt++;
        else icnt++;
      end
      tick();
    end
    clr_in();
    chk("perr_icnt", icnt, 1);
    chk("perr_dcnt", dcnt, 1);
    chk("perr_sticky", ifc4.protocol_err, 1);

    // async reset during DELAY
    ifc4.icache_req_valid = 1'b1;
    tick();
    clr_in();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mreq", ifc4.mm_req_valid, 0);
    chk("ar_perr", ifc4.protocol_err, 0);
    chk("ar_info", ifc4.mm_req_info.addr, 0);
    chk("ar_data", ifc4.rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    icnt = 0;
    for (int k = 0; k < 20; k++) begin
      ifc4.mm_rsp_valid = ifc4.mm_req_valid;
      if (ifc4.rsp_valid || ifc4.mm_req_valid) icnt++;
      tick();
    end
    clr_in();
    chk("ar_no_rsp", icnt, 0);

    // bus error, zero request latency
    do_reset();
    ifc0.dcache_req_valid = 1'b1;
    tick();
    clr_in();
    chk("be_mreq_c1", ifc0.mm_req_valid, 1);
    ifc0.mm_rsp_valid     = 1'b1;
    ifc0.mm_rsp_bus_error = 1'b1;
    tick();
    clr_in();
    chk("be_rsp", {ifc0.rsp_valid, ifc0.rsp_bus_error}, 2'b11);
    chk("be_id", ifc0.rsp_cache_id, 1);
    tick();
    chk("be_rsp_pulse", ifc0.rsp_valid, 0);

    // back-to-back contention over 6 transactions
    do_reset();
    ifc4.icache_req_valid = 1'b1;
    ifc4.dcache_req_valid = 1'b1;
    tick();
    clr_in();
    for (int t = 0; t < 6; t++) begin
      got = 1'b0;
      id  = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        ifc4.mm_rsp_valid = ifc4.mm_req_valid;
        if (ifc4.rsp_valid) begin
          got = 1'b1;
          id  = ifc4.rsp_cache_id;
          if (id) ifc4.dcache_req_valid = 1'b1;
          else    ifc4.icache_req_valid = 1'b1;
        end
        tick();
        clr_in();
      end
      chk($sformatf("fair%0d_seen", t), got, 1);
      if (got)
        chk($sformatf("fair%0d_id", t), id,
            FAIR ? ((t % 2) == 0) : 1'b1);
    end
    chk("fair_perr", ifc4.protocol_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
